sr_stack: RTL and testbench
===========================

# sr_stack

Parametrised successor to the 8-bit CPU's status/result register. It captures the ALU result on any active ALU-operation strobe, and keeps a DEPTH-entry LIFO history of results. Each entry carries its carry bit and the index of the operation that produced it. The newest entry drives the data bus through an active-low tri-state enable, and the CPU can pop entries back to recover earlier results.

## Interface
- WIDTH, 8, data width of the result path
- DEPTH, 4, number of history entries (≥2, power of two not required)
- NOPS, 6, number of active-low ALU operation strobes
- IW, $clog2(NOPS), width of the stored operation index (derived, not overridable)
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- OPn  in  NOPS  active-low ALU operation strobes (SUM, SUB, MUL, DIV, SHL, SHR in bits 0..5 by default)
- Cin  in  1  ALU carry/borrow out, sampled with Dsrin
- Dsrin  in  WIDTH  ALU result
- POPn  in  1  active-low pop of newest entry
- CLRn  in  1  active-low clear of sticky error flags
- ESRn  in  1  active-low output enable for Dout
- Dout  out  WIDTH  newest entry's data when ESRn=0, high-impedance when ESRn=1
- OPIDX  out  IW  operation index of newest entry
- FZ, FN, FC  out  1 each  zero / negative (MSB) / carry of newest entry
- EMPTY, FULL  out  1 each  occupancy status
- OVF, UNF  out  1 each  sticky: push while full / pop while empty

## Operation
- Push condition: any bit of OPn low at the clock edge.
  - Multiple strobes low at once produce one push.
  - OPIDX stores the lowest-numbered active bit.
- Entry format: {Dsrin, Cin, opidx}.
- Count register 0..DEPTH plus a head pointer into a circular array.
- Push, not full: write at head+1, head advances, count+1.
- Push when full: the oldest entry is overwritten (circular wrap), count stays DEPTH, OVF set.
- Pop (POPn=0), not empty: head retreats by one with wrap, count−1. Entry contents are not cleared.
- Pop when empty: no state change, UNF set.
- Push and pop in the same cycle:
  - count>0: the head entry is replaced by the new result; count and head pointer unchanged.
  - count=0: treated as a plain push (count becomes 1), UNF not set.
- CLRn=0 clears OVF and UNF. Same-cycle set has priority over clear.
- Flags are combinational from the head entry:
  - FZ = (data==0)
  - FN = data[WIDTH-1]
  - FC = stored carry
- When EMPTY: Dout (if enabled) reads 0, FZ=1, FN=0, FC=0, OPIDX=0.
- ESRn affects only Dout drive. It never affects state.
- Reset: count=0, head=0, OVF=UNF=0. Outputs after reset are EMPTY=1, FULL=0, FZ=1, FN=FC=0, OPIDX=0, Dout=Z (if ESRn=1) or 0.

## Timing
- Push-to-visible latency is 1 cycle: the result sampled at edge k appears on Dout, flags and OPIDX after edge k.
- Pop takes effect after the edge; the previous entry is visible in the same cycle that EMPTY/count update.
- Dout enable/disable is combinational on ESRn, with no clock dependence.
- Sticky flags assert the cycle after the offending edge and hold until CLRn or RST.
- RST has priority over every other input; a push or pop in the reset cycle is discarded.

## Test plan
- Reset then ESRn=0, no strobes -> Dout=0x00, EMPTY=1, FZ=1, OVF=UNF=0; with ESRn=1, Dout=Z.
- OPn=6'b111110 with Dsrin=0x80, Cin=1 -> next cycle Dout=0x80, FN=1, FC=1, FZ=0, OPIDX=0, EMPTY=0.
- Push 0x11, 0x22, 0x33, 0x44 (FULL=1), then push 0x55 -> OVF=1, FULL=1. Four pops then read 0x55, 0x44, 0x33, 0x22. A further pop sets UNF=1 and leaves EMPTY=1.
- Push 0x0A, then push 0x0B with POPn=0 in the same cycle -> count stays 1, Dout=0x0B. One more pop -> EMPTY=1.
- OPn=6'b101011 (bits 2 and 4 low) with Dsrin=0x00 -> single push, OPIDX=2, FZ=1. Pulse CLRn after an OVF -> OVF=0.
- Three entries loaded, then RST=1 together with OPn low -> EMPTY=1, no push recorded, Dout=0.

Source files
------------

// File: rtl/sr_stack.sv
// Status/result register with a DEPTH-entry LIFO history of ALU results.
// The newest entry drives Dout (tri-state) and the FZ/FN/FC/OPIDX flags.
module sr_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NOPS  = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NOPS-1:0]  OPn,
  input  logic             Cin,
  input  logic [WIDTH-1:0] Dsrin,
  input  logic             POPn,
  input  logic             CLRn,
  input  logic             ESRn,
  output logic [WIDTH-1:0] Dout,
  output logic [((NOPS > 1) ? $clog2(NOPS) : 1)-1:0] OPIDX,
  output logic             FZ,
  output logic             FN,
  output logic             FC,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF
);

  localparam int unsigned IW = (NOPS > 1) ? $clog2(NOPS) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data  [DEPTH];
  logic             r_carry [DEPTH];
  logic [IW-1:0]    r_op    [DEPTH];
  logic [PW-1:0]    r_head;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_replace;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [IW-1:0] w_opidx;
  logic [PW-1:0] w_head_inc;
  logic [PW-1:0] w_head_dec;

  assign w_push  = ~(&OPn);
  assign w_pop   = ~POPn;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // Push together with pop on a non-empty stack rewrites the head in place.
  assign w_replace = w_push & w_pop & ~w_empty;
  assign w_ovf_set = w_push & ~w_replace & w_full;
  assign w_unf_set = w_pop & ~w_push & w_empty;

  assign w_head_inc = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_head_dec = (r_head == '0) ? PW'(DEPTH - 1) : r_head - 1'b1;

  // Lowest-numbered active strobe wins.
  always_comb begin
    w_opidx = '0;
    for (int i = int'(NOPS) - 1; i >= 0; i--) begin
      if (!OPn[i]) w_opidx = IW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push && !w_replace) begin
        r_head <= w_head_inc;
        if (!w_full) r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push && !w_empty) begin
        r_head  <= w_head_dec;
        r_count <= r_count - 1'b1;
      end
      r_ovf <= w_ovf_set | (r_ovf & CLRn);
      r_unf <= w_unf_set | (r_unf & CLRn);
    end
  end

  // Entry storage carries no reset; EMPTY masks stale contents.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      if (w_replace) begin
        r_data[r_head]  <= Dsrin;
        r_carry[r_head] <= Cin;
        r_op[r_head]    <= w_opidx;
      end else begin
        r_data[w_head_inc]  <= Dsrin;
        r_carry[w_head_inc] <= Cin;
        r_op[w_head_inc]    <= w_opidx;
      end
    end
  end

  logic [WIDTH-1:0] w_top_data;

  assign w_top_data = w_empty ? '0 : r_data[r_head];
  assign FZ    = (w_top_data == '0);
  assign FN    = w_top_data[WIDTH-1];
  assign FC    = w_empty ? 1'b0 : r_carry[r_head];
  assign OPIDX = w_empty ? '0 : r_op[r_head];
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;
  assign Dout  = ESRn ? 'z : w_top_data;

endmodule

// File: tb/tb_sr_stack.sv
// Bench for sr_stack: directed test-plan steps then random traffic, all checked
// against a queue-based LIFO model.
module tb_sr_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NOPS  = 6;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NOPS-1:0]  OPn;
  logic             Cin;
  logic [WIDTH-1:0] Dsrin;
  logic             POPn;
  logic             CLRn;
  logic             ESRn;
  wire  [WIDTH-1:0] Dout;
  logic [2:0]       OPIDX;
  logic             FZ, FN, FC, EMPTY, FULL, OVF, UNF;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             c;
    logic [2:0]       op;
  } ent_t;

  ent_t m_q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  sr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOPS(NOPS)) dut (
    .CLK(CLK), .RST(RST), .OPn(OPn), .Cin(Cin), .Dsrin(Dsrin), .POPn(POPn),
    .CLRn(CLRn), .ESRn(ESRn), .Dout(Dout), .OPIDX(OPIDX), .FZ(FZ), .FN(FN),
    .FC(FC), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t e;
    logic [WIDTH-1:0] td;
    logic [31:0] exp_dout;
    if (m_q.size() == 0) begin
      td = '0;
      e.c = 1'b0;
      e.op = '0;
    end else begin
      e = m_q[m_q.size()-1];
      td = e.d;
    end
    exp_dout = ESRn ? {24'b0, 8'bzzzzzzzz} : {24'b0, td};
    chk({tag, ".Dout"},  {24'b0, Dout}, exp_dout);
    chk({tag, ".OPIDX"}, {29'b0, OPIDX}, {29'b0, e.op});
    chk({tag, ".FZ"},    {31'b0, FZ}, {31'b0, td == 0});
    chk({tag, ".FN"},    {31'b0, FN}, {31'b0, td[WIDTH-1]});
    chk({tag, ".FC"},    {31'b0, FC}, {31'b0, e.c});
    chk({tag, ".EMPTY"}, {31'b0, EMPTY}, {31'b0, m_q.size() == 0});
    chk({tag, ".FULL"},  {31'b0, FULL}, {31'b0, m_q.size() == DEPTH});
    chk({tag, ".OVF"},   {31'b0, OVF}, {31'b0, m_ovf});
    chk({tag, ".UNF"},   {31'b0, UNF}, {31'b0, m_unf});
  endtask

  task automatic model_step(input logic [NOPS-1:0] op, input logic [WIDTH-1:0] d,
                            input logic c, input logic pop_n, input logic clr_n,
                            input logic rst);
    ent_t e;
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (op != '1) begin
        e.d = d;
        e.c = c;
        e.op = '0;
        for (int i = 0; i < NOPS; i++) begin
          if (!op[i]) begin
            e.op = 3'(i);
            break;
          end
        end
        if (!pop_n && m_q.size() > 0) begin
          m_q[m_q.size()-1] = e;
        end else begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            so = 1'b1;
          end
          m_q.push_back(e);
        end
      end else if (!pop_n) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
        else su = 1'b1;
      end
      if (!clr_n) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | so;
      m_unf = m_unf | su;
    end
  endtask

  task automatic cyc(input string tag, input logic [NOPS-1:0] op, input logic [WIDTH-1:0] d,
                     input logic c, input logic pop_n, input logic clr_n, input logic rst);
    OPn = op; Dsrin = d; Cin = c; POPn = pop_n; CLRn = clr_n; RST = rst;
    @(posedge CLK);
    model_step(op, d, c, pop_n, clr_n, rst);
    #1;
    OPn = '1; POPn = 1'b1; CLRn = 1'b1; RST = 1'b0;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] d);
    cyc(tag, 6'b111110, d, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pop(input string tag);
    cyc(tag, 6'b111111, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    OPn = '1; Dsrin = '0; Cin = 1'b0; POPn = 1'b1; CLRn = 1'b1; ESRn = 1'b0; RST = 1'b1;
    cyc("reset", '1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("idle", '1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    ESRn = 1'b1; #1; check_all("hiz");
    ESRn = 1'b0; #1; check_all("drive");

    cyc("push80", 6'b111110, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    pop("pop80");

    push("p11", 8'h11); push("p22", 8'h22); push("p33", 8'h33); push("p44", 8'h44);
    push("p55_ovf", 8'h55);
    pop("pop1"); pop("pop2"); pop("pop3"); pop("pop4");
    pop("pop_unf");
    cyc("clr", '1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    push("p0A", 8'h0A);
    cyc("push_pop", 6'b111110, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0);
    pop("pop_0B");
    cyc("push_pop_empty", 6'b111110, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b0);
    pop("pop_0C");

    cyc("multi_strobe", 6'b101011, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    push("f1", 8'h01); push("f2", 8'h02); push("f3", 8'h03); push("f4_ovf", 8'h04);
    cyc("clr_ovf", '1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("set_vs_clr", 6'b110111, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);

    cyc("rst_a", '1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    push("r1", 8'hA1); push("r2", 8'hA2); push("r3", 8'hA3);
    cyc("rst_push", 6'b111101, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [NOPS-1:0] op;
      op = ($urandom_range(0, 1) == 0) ? 6'h3F : NOPS'($urandom);
      ESRn = ($urandom_range(0, 3) == 0);
      cyc("rand", op, 8'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
